// File: rtl/gray_up_down_counter.sv
// gray_up_down_counter: registered up/down binary count presented as Gray code, with load, wrap/saturate and terminal-count pulse
module gray_up_down_counter #(
   parameter int WIDTH = 4,
   parameter bit WRAP  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_gray,
   output logic [WIDTH-1:0] gray_out,
   output logic [WIDTH-1:0] bin_out,
   output logic             tc,
   output logic             sat
);
   localparam logic [WIDTH-1:0] ONES = '1;
   logic [WIDTH-1:0] load_bin, step, bin_next;
   logic at_limit, arrive, tc_next;
   // Each binary bit is the XOR of all Gray bits at or above it.
   for (genvar i = 0; i < WIDTH; i++) begin : g_dec
      assign load_bin[i] = ^load_gray[WIDTH-1:i];
   end
   always_comb begin
      at_limit = up ? bin_out == ONES : bin_out == '0;
      arrive   = up ? bin_out == ONES - 1'b1 : bin_out == WIDTH'(1);
      step     = up ? bin_out + 1'b1 : bin_out - 1'b1;
      bin_next = load ? load_bin : (en && (WRAP || !at_limit)) ? step : bin_out;
      tc_next  = !load && en && (WRAP ? at_limit : arrive);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_out  <= '0;
         gray_out <= '0;
         tc       <= 1'b0;
      end else begin
         bin_out  <= bin_next;
         gray_out <= bin_next ^ (bin_next >> 1);
         tc       <= tc_next;
      end
   end
   assign sat = !WRAP && at_limit;
endmodule
